// File: rtl/act_pkg.sv
// Shared types and helpers for the activation LUT loader and its readers.
package act_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      FLUSH
   } loader_state_t;

   function automatic int lut_depth(input int in_width);
      return 1 << in_width;
   endfunction

   // Offset-binary mapping: the most negative input lands on address 0.
   function automatic int lut_addr(input int x, input int in_width);
      return x ^ (1 << (in_width - 1));
   endfunction

endpackage

// File: rtl/act_lut_loader.sv
// Streams activation-table words into the LUT RAM write port and reports
// completion, length errors and table validity.
module act_lut_loader
   import act_pkg::*;
#(
   parameter int inWidth   = 10,
   parameter int dataWidth = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [dataWidth-1:0] s_data,
   input  logic                 s_last,
   output logic                 wr_en,
   output logic [inWidth-1:0]   wr_addr,
   output logic [dataWidth-1:0] wr_data,
   output logic                 busy,
   output logic                 done,
   output logic                 err_len,
   output logic                 lut_valid
);

   localparam int CNT_W = inWidth + 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(lut_depth(inWidth) - 1);

   // Handshake: a beat transfers on a rising edge where s_valid and s_ready
   // are both high; s_ready depends only on state, never on s_valid.
   loader_state_t    state;
   loader_state_t    state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             accept;
   logic             at_last;

   assign s_ready = (state != IDLE);
   assign busy    = (state != IDLE);
   assign accept  = s_valid & s_ready;
   assign at_last = (cnt == LAST_IDX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) state_nxt = LOAD;
         end
         LOAD: begin
            if (accept) begin
               if (s_last)       state_nxt = IDLE;
               else if (at_last) state_nxt = FLUSH;
            end
         end
         FLUSH: begin
            if (accept && s_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Write port and status flags are registered from the accepting edge,
   // so the final write and done land in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         done      <= 1'b0;
         err_len   <= 1'b0;
         lut_valid <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  cnt       <= '0;
                  err_len   <= 1'b0;
                  lut_valid <= 1'b0;
               end
            end
            LOAD: begin
               if (accept) begin
                  wr_en   <= 1'b1;
                  wr_addr <= cnt[inWidth-1:0];
                  wr_data <= s_data;
                  cnt     <= cnt + CNT_W'(1);
                  if (s_last) begin
                     if (at_last) begin
                        done      <= 1'b1;
                        lut_valid <= 1'b1;
                     end else begin
                        err_len <= 1'b1;
                     end
                  end
               end
            end
            FLUSH: begin
               if (accept && s_last) err_len <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_act_lut_loader.sv
// Directed bench for act_lut_loader at inWidth = 4: table-driven loads plus
// hand-written reset, stray-start and idle-valid sequences.
module tb_act_lut_loader;

   localparam int IW = 4;
   localparam int DW = 16;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [DW-1:0] s_data = '0;
   logic          s_last = 1'b0;
   logic          wr_en;
   logic [IW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          busy;
   logic          done;
   logic          err_len;
   logic          lut_valid;

   act_lut_loader #(.inWidth(IW), .dataWidth(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_last    (s_last),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .busy      (busy),
      .done      (done),
      .err_len   (err_len),
      .lut_valid (lut_valid)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Model: a write is due one cycle after each accepted beat while fewer
   // than DEPTH beats of the current load have been taken.
   int   beat_idx = 0;
   logic exp_we = 1'b0;
   int   done_cnt = 0;
   logic [IW+DW-1:0] got_q[$];
   logic [IW+DW-1:0] exp_q[$];

   always @(posedge clk) begin
      if (rst) begin
         exp_we = 1'b0;
      end else begin
         exp_we = s_valid && s_ready && (beat_idx < DEPTH);
         if (s_valid && s_ready) beat_idx++;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (wr_en !== exp_we) chk("wr_en_timing", 32'(wr_en), 32'(exp_we));
         if (wr_en) got_q.push_back({wr_addr, wr_data});
         if (done) begin
            done_cnt++;
            chk("done_with_final_write", {wr_en, 27'd0, wr_addr}, {1'b1, 27'd0, 4'hf});
         end
      end
   end

   task automatic do_start();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      beat_idx = 0;
      done_cnt = 0;
      got_q.delete();
   endtask

   task automatic run_beats(input int n, input int last_at, input int gap, input int stray_at);
      int cyc = 0;
      for (int i = 0; i < n; i++) begin
         if (gap > 0 && (cyc % gap) == gap - 1) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
            cyc++;
         end
         s_valid = 1'b1;
         s_data  = DW'(16'h100 + i);
         s_last  = (i == last_at);
         start   = (i == stray_at);
         @(posedge clk); #1;
         start = 1'b0;
         cyc++;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic check_writes(input string name, input int nw);
      exp_q.delete();
      for (int i = 0; i < nw; i++) exp_q.push_back({IW'(i), DW'(16'h100 + i)});
      chk({name, "_write_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk({name, "_write"}, 32'(got_q[i]), 32'(exp_q[i]));
   endtask

   typedef struct {
      string name;
      int    n;
      int    last_at;
      int    gap;
      int    exp_writes;
      int    exp_done;
      logic  exp_err;
      logic  exp_valid;
   } vec_t;

   vec_t vecs[4];

   initial begin
      vecs[0] = '{"full",  16, 15, 0, 16, 1, 1'b0, 1'b1};
      vecs[1] = '{"gaps",  16, 15, 3, 16, 1, 1'b0, 1'b1};
      vecs[2] = '{"short", 10,  9, 0, 10, 0, 1'b1, 1'b0};
      vecs[3] = '{"long",  20, 19, 0, 16, 0, 1'b1, 1'b0};

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {wr_en, busy, done, err_len, lut_valid, s_ready}, 6'b0);
      chk("reset_addr_data", {wr_addr, wr_data}, '0);
      @(posedge clk); #1;
      rst = 1'b0;

      // s_valid while idle is not accepted
      s_valid = 1'b1;
      s_data  = 16'hdead;
      @(negedge clk);
      chk("idle_ready_low", 32'(s_ready), 32'd0);
      @(posedge clk); #1;
      s_valid = 1'b0;
      @(negedge clk);
      chk("idle_no_write", {wr_en, busy}, 2'b00);

      for (int v = 0; v < 4; v++) begin
         do_start();
         @(negedge clk);
         chk({vecs[v].name, "_busy"}, 32'(busy), 32'd1);
         run_beats(vecs[v].n, vecs[v].last_at, vecs[v].gap, -1);
         check_writes(vecs[v].name, vecs[v].exp_writes);
         chk({vecs[v].name, "_done"}, done_cnt, vecs[v].exp_done);
         chk({vecs[v].name, "_flags"}, {busy, err_len, lut_valid},
             {1'b0, vecs[v].exp_err, vecs[v].exp_valid});
      end

      // A fresh start clears the sticky error
      do_start();
      @(negedge clk);
      chk("restart_clears_err", {busy, err_len, lut_valid}, 3'b100);

      // Reset after beat 7 aborts the load
      run_beats(8, -1, 0, -1);
      check_writes("pre_reset", 8);
      rst = 1'b1;
      @(negedge clk);
      chk("midload_reset", {wr_en, busy, done, err_len, lut_valid, s_ready}, 6'b0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Full load with a stray start on beat 5
      do_start();
      run_beats(16, 15, 0, 5);
      check_writes("stray_start", 16);
      chk("stray_start_done", done_cnt, 1);
      chk("stray_start_flags", {busy, err_len, lut_valid}, 3'b001);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL timeout: simulation exceeded time limit");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
